serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 104 ++++++++++
 tb/tb_serial_add_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial 4-bit adder/subtractor: one full-adder cell walks the operands LSB-first over four cycles.
// Optional signed-overflow output is built when SERIAL_ADD_OVF_EN is defined.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic              ovf,
`endif
  output logic              cout
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] opa, opb;
  logic [DATA_W-2:0] part;
  logic              carry;
  logic [CNT_W-1:0]  cnt;
  logic              fa_s, fa_co;
  logic              last_bit;

  full_adder u_fa (
    .a  (opa[0]),
    .b  (opb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == CNT_W'(DATA_W - 1));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      part  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        // Subtraction is A + ~B + 1, so the inversion and forced carry happen at capture.
        opa   <= a;
        opb   <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        opa   <= opa >> 1;
        opb   <= opb >> 1;
        carry <= fa_co;
        part  <= {fa_s, part[DATA_W-2:1]};
        cnt   <= cnt + 1'b1;
        if (last_bit) begin
          sum  <= {fa_s, part};
          cout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
          // On the last bit the carry register holds the carry into the MSB.
          ovf  <= carry ^ fa_co;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: arithmetic reference model, directed cases, random traffic.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, cin, sub;
  logic [3:0] a, b;
  logic       busy, done, cout;
  logic [3:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  serial_add_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: t counts edges since the capture edge (-1 when idle).
  int         t = -1;
  logic [3:0] m_sum = 4'd0, p_sum;
  logic       m_cout = 1'b0, m_ovf = 1'b0, p_cout, p_ovf;

  always @(posedge clk) begin
    logic [3:0] bv;
    logic [4:0] full;
    if (rst) begin
      t = -1; m_sum = 4'd0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (t < 0) begin
      if (start) begin
        bv     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bv} + {4'd0, (sub ? 1'b1 : cin)};
        p_sum  = full[3:0];
        p_cout = full[4];
        p_ovf  = (a[3] == bv[3]) && (p_sum[3] != a[3]);
        t = 0;
      end
    end else begin
      t++;
      if (t == 4) begin
        m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end else if (t == 5) begin
        t = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("busy", int'(busy), int'(t >= 0));
      chk("done", int'(done), int'(t == 4));
      chk("sum", int'(sum), int'(m_sum));
      chk("cout", int'(cout), int'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", int'(ovf), int'(m_ovf));
`endif
    end
  end

  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic ic, input logic is,
                        input int es, input int ec, input int eo);
    int lat;
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
    else begin
      chk("latency", lat, 5);
      chk("lit_sum", int'(sum), es);
      chk("lit_cout", int'(cout), ec);
      chk("model_ovf", int'(m_ovf), eo);
`ifdef SERIAL_ADD_OVF_EN
      chk("lit_ovf", int'(ovf), eo);
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    int ndone, first, second;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sum", int'(sum), 0);
    // Reset beats start in the same cycle.
    start = 1'b1;
    @(negedge clk);
    chk("rst_over_start", int'(busy), 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    run_op(4'd3, 4'd5, 1'b0, 1'b0, 8, 0, 1);
    run_op(4'd15, 4'd1, 1'b0, 1'b0, 0, 1, 0);
    run_op(4'd15, 4'd0, 1'b1, 1'b0, 0, 1, 0);
    run_op(4'd5, 4'd3, 1'b1, 1'b1, 2, 1, 0);
    run_op(4'd3, 4'd5, 1'b0, 1'b1, 14, 0, 0);

    // Second start during RUN is ignored.
    a = 4'd1; b = 4'd1; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd7; b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        chk("guard_sum", int'(sum), 2);
      end
      @(negedge clk);
    end
    chk("guard_ndone", ndone, 1);

    // Held start: one op every 6 cycles.
    a = 4'd2; b = 4'd6; start = 1'b1;
    ndone = 0; first = -1; second = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) first = i; else second = i;
      end
    end
    start = 1'b0;
    chk("held_ndone", ndone, 2);
    chk("held_gap", second - first, 6);
    repeat (2) @(negedge clk);

    // Reset on the second RUN edge aborts the op.
    a = 4'd9; b = 4'd9; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sum", int'(sum), 0);
    chk("abort_cout", int'(cout), 0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_ndone", ndone, 0);

    // Random traffic, including inputs changing mid-op and occasional resets.
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a     = 4'($urandom);
      b     = 4'($urandom);
      cin   = 1'($urandom);
      sub   = 1'($urandom);
      rst   = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
